// File: rtl/qspi_flash_responder_if.sv
// Bus bundle between the QSPI controller side and the flash responder:
// the QSPI pins plus the responder's memory fetch port and status outputs.
`timescale 1ns/1ps
interface qspi_flash_responder_if #(
    parameter int MEM_AW = 16
);
    logic              spi_clk;
    logic              cs_n;
    logic [3:0]        io_in;
    logic [3:0]        io_out;
    logic [3:0]        io_oe;
    logic              mem_rd;
    logic [MEM_AW:0]   mem_addr;
    logic [7:0]        mem_rdata;
    logic              active_die;
    logic              cmd_err;

    modport master (
        output spi_clk, cs_n, io_in, mem_rdata,
        input  io_out, io_oe, mem_rd, mem_addr, active_die, cmd_err
    );

    modport slave (
        input  spi_clk, cs_n, io_in, mem_rdata,
        output io_out, io_oe, mem_rd, mem_addr, active_die, cmd_err
    );
endinterface

// File: rtl/qspi_flash_responder.sv
// QSPI NOR-flash target: decodes 4-byte-address 1-1-1/1-1-2/1-1-4 reads and a
// die-select command, prefetches bytes from a memory port and shifts them out.
`timescale 1ns/1ps
module qspi_flash_responder #(
    parameter int MEM_AW       = 16,
    parameter int DUMMY_CYCLES = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 system_clk,
    input  logic                 system_reset,
    qspi_flash_responder_if.slave bus
);
    localparam int SR_W = (MEM_AW > 8) ? MEM_AW : 8;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DIE, S_DUMMY, S_DATA, S_IGNORE
    } state_t;

    typedef enum logic [1:0] {LANE_1, LANE_2, LANE_4} lanes_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, io0_sync;
    logic sclk_prev, cs_prev;
    logic sclk_s, cs_s, io0_s, spi_rise, spi_fall, cs_fall;

    // Only io0 carries controller data for the supported command set.
    logic unused_io;
    assign unused_io = ^bus.io_in[3:1];

    always_ff @(posedge system_clk) begin
        if (system_reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            io0_sync  <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync[0] <= bus.spi_clk;
            cs_sync[0]   <= bus.cs_n;
            io0_sync[0]  <= bus.io_in[0];
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                cs_sync[i]   <= cs_sync[i-1];
                io0_sync[i]  <= io0_sync[i-1];
            end
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s   = sclk_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign io0_s    = io0_sync[SYNC_STAGES-1];
    assign spi_rise = sclk_s & ~sclk_prev;
    assign spi_fall = ~sclk_s & sclk_prev;
    assign cs_fall  = ~cs_s & cs_prev;

    state_t            state, state_n;
    lanes_t            lanes, lanes_n;
    logic [5:0]        cnt, cnt_n;
    logic [SR_W-2:0]   sr, sr_n;
    logic [SR_W-1:0]   sr_in;
    logic [MEM_AW-1:0] addr, addr_n, addr_inc;
    logic [7:0]        cur, cur_n, nxt, nxt_n, src;
    logic [2:0]        beat, beat_n, beat_last;
    logic              rd_pending, rd_pending_n;
    logic [3:0]        io_out_q, io_out_n, io_oe_q, io_oe_n;
    logic              mem_rd_q, mem_rd_n, die_q, die_n, cmd_err_q, cmd_err_n;
    logic [MEM_AW:0]   mem_addr_q, mem_addr_n;

    assign sr_in    = {sr, io0_s};
    assign addr_inc = addr + 1'b1;
    assign src      = (beat == 3'd0) ? nxt : cur;

    always_comb begin
        state_n      = state;
        lanes_n      = lanes;
        cnt_n        = cnt;
        sr_n         = sr;
        addr_n       = addr;
        cur_n        = cur;
        nxt_n        = nxt;
        beat_n       = beat;
        beat_last    = 3'd1;
        rd_pending_n = mem_rd_q;
        io_out_n     = io_out_q;
        io_oe_n      = io_oe_q;
        mem_rd_n     = 1'b0;
        mem_addr_n   = mem_addr_q;
        die_n        = die_q;
        cmd_err_n    = 1'b0;

        if (rd_pending) nxt_n = bus.mem_rdata;

        case (state)
            S_IDLE: begin
                if (cs_fall) begin
                    state_n = S_CMD;
                    cnt_n   = '0;
                end
            end
            S_CMD: begin
                if (spi_rise) begin
                    sr_n  = sr_in[SR_W-2:0];
                    cnt_n = cnt + 6'd1;
                    if (cnt == 6'd7) begin
                        cnt_n = '0;
                        case (sr_in[7:0])
                            8'h13: begin state_n = S_ADDR; lanes_n = LANE_1; end
                            8'h3C: begin state_n = S_ADDR; lanes_n = LANE_2; end
                            8'h6C: begin state_n = S_ADDR; lanes_n = LANE_4; end
                            8'hC2: state_n = S_DIE;
                            default: begin
                                state_n   = S_IGNORE;
                                cmd_err_n = 1'b1;
                            end
                        endcase
                    end
                end
            end
            S_ADDR: begin
                if (spi_rise) begin
                    sr_n  = sr_in[SR_W-2:0];
                    cnt_n = cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        // First byte is fetched as soon as the address is complete.
                        cnt_n      = '0;
                        beat_n     = '0;
                        addr_n     = sr_in[MEM_AW-1:0];
                        mem_rd_n   = 1'b1;
                        mem_addr_n = {die_q, sr_in[MEM_AW-1:0]};
                        state_n    = (lanes == LANE_1 || DUMMY_CYCLES == 0) ? S_DATA : S_DUMMY;
                    end
                end
            end
            S_DIE: begin
                if (spi_rise) begin
                    cnt_n = cnt + 6'd1;
                    if (cnt == 6'd7) begin
                        die_n   = io0_s;
                        state_n = S_IGNORE;
                    end
                end
            end
            S_DUMMY: begin
                if (spi_rise) begin
                    cnt_n = cnt + 6'd1;
                    if (cnt == 6'(DUMMY_CYCLES - 1)) state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (spi_fall) begin
                    case (lanes)
                        LANE_1: begin
                            io_out_n  = {2'b00, src[7], 1'b0};
                            io_oe_n   = 4'b0010;
                            cur_n     = {src[6:0], 1'b0};
                            beat_last = 3'd7;
                        end
                        LANE_2: begin
                            io_out_n  = {2'b00, src[7:6]};
                            io_oe_n   = 4'b0011;
                            cur_n     = {src[5:0], 2'b00};
                            beat_last = 3'd3;
                        end
                        default: begin
                            io_out_n  = src[7:4];
                            io_oe_n   = 4'b1111;
                            cur_n     = {src[3:0], 4'b0000};
                            beat_last = 3'd1;
                        end
                    endcase
                    beat_n = (beat == beat_last) ? 3'd0 : beat + 3'd1;
                    // Starting a byte from the prefetch buffer triggers the next fetch.
                    if (beat == 3'd0) begin
                        addr_n     = addr_inc;
                        mem_rd_n   = 1'b1;
                        mem_addr_n = {die_q, addr_inc};
                    end
                end
            end
            default: ;
        endcase

        if (cs_s) begin
            state_n  = S_IDLE;
            io_oe_n  = '0;
            io_out_n = '0;
            mem_rd_n = 1'b0;
        end
    end

    always_ff @(posedge system_clk) begin
        if (system_reset) begin
            state      <= S_IDLE;
            lanes      <= LANE_1;
            cnt        <= '0;
            sr         <= '0;
            addr       <= '0;
            cur        <= '0;
            nxt        <= '0;
            beat       <= '0;
            rd_pending <= 1'b0;
            io_out_q   <= '0;
            io_oe_q    <= '0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            die_q      <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state      <= state_n;
            lanes      <= lanes_n;
            cnt        <= cnt_n;
            sr         <= sr_n;
            addr       <= addr_n;
            cur        <= cur_n;
            nxt        <= nxt_n;
            beat       <= beat_n;
            rd_pending <= rd_pending_n;
            io_out_q   <= io_out_n;
            io_oe_q    <= io_oe_n;
            mem_rd_q   <= mem_rd_n;
            mem_addr_q <= mem_addr_n;
            die_q      <= die_n;
            cmd_err_q  <= cmd_err_n;
        end
    end

    assign bus.io_out     = io_out_q;
    assign bus.io_oe      = io_oe_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.active_die = die_q;
    assign bus.cmd_err    = cmd_err_q;
endmodule

// File: tb/tb_qspi_flash_responder.sv
// Self-checking bench for qspi_flash_responder: directed test-plan transactions
// followed by random commands, checked against a byte-stream reference model.
`timescale 1ns/1ps
module tb_qspi_flash_responder;
    localparam int MEM_AW = 16;
    localparam int DUMMY  = 8;
    localparam int SYNC   = 2;
    localparam int H      = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    qspi_flash_responder_if #(.MEM_AW(MEM_AW)) bus();

    qspi_flash_responder #(
        .MEM_AW(MEM_AW), .DUMMY_CYCLES(DUMMY), .SYNC_STAGES(SYNC)
    ) dut (
        .system_clk(clk),
        .system_reset(rst),
        .bus(bus)
    );

    logic [7:0]      mem [0:(1<<(MEM_AW+1))-1];
    logic [MEM_AW:0] fetch_q[$];
    int              err_pulses = 0;
    int              tests = 0;
    int              fails = 0;
    logic            die_m = 1'b0;

    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.mem_rdata <= mem[bus.mem_addr];
            fetch_q.push_back(bus.mem_addr);
        end
        if (bus.cmd_err) err_pulses++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b);
        bus.io_in = {3'b000, b};
        wait_clk(H);
        bus.spi_clk = 1'b1;
        wait_clk(H);
        bus.spi_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic cs_low();
        bus.cs_n = 1'b0;
        wait_clk(SYNC + 3);
    endtask

    task automatic cs_high_check(input logic [3:0] oe_before);
        wait_clk(H);
        bus.cs_n = 1'b1;
        wait_clk(SYNC);
        chk("oe_hold", 32'(bus.io_oe), 32'(oe_before));
        wait_clk(1);
        chk("oe_off", 32'(bus.io_oe), 32'h0);
        wait_clk(4);
    endtask

    // Expected data: byte k of the stream is mem[{die, addr+k mod 2^AW}], sliced MSB first.
    task automatic do_read(input logic [7:0] op, input logic [31:0] a32, input int n);
        int beats, started, k, s, err0;
        logic [3:0] oe_e, io_e;
        logic [7:0] b;
        logic [MEM_AW-1:0] a, ai;
        a    = a32[MEM_AW-1:0];
        beats = (op == 8'h13) ? 8 : (op == 8'h3C) ? 4 : 2;
        oe_e  = (op == 8'h13) ? 4'b0010 : (op == 8'h3C) ? 4'b0011 : 4'b1111;
        err0  = err_pulses;
        fetch_q.delete();
        cs_low();
        send_byte(op);
        for (int i = 31; i >= 0; i--) spi_bit(a32[i]);
        if (op != 8'h13) begin
            for (int d = 0; d < DUMMY; d++) begin
                spi_bit(1'b0);
                chk("dummy_oe", 32'(bus.io_oe), 32'h0);
            end
        end
        for (int j = 1; j <= n; j++) begin
            wait_clk(H);
            k  = (j - 1) / beats;
            s  = (j - 1) % beats;
            ai = a + MEM_AW'(k);
            b  = mem[{die_m, ai}];
            if (beats == 8)      io_e = {2'b00, b[7 - s], 1'b0};
            else if (beats == 4) io_e = 4'((b >> (6 - 2 * s)) & 8'h3);
            else                 io_e = 4'((b >> (4 - 4 * s)) & 8'hF);
            chk("data", 32'(bus.io_out & oe_e), 32'(io_e));
            chk("data_oe", 32'(bus.io_oe), 32'(oe_e));
            bus.spi_clk = 1'b1;
            wait_clk(H);
            bus.spi_clk = 1'b0;
        end
        cs_high_check(oe_e);
        started = n / beats + 1;
        chk("fetch_cnt", 32'(fetch_q.size()), 32'(started + 1));
        for (int i = 0; i < fetch_q.size() && i <= started; i++) begin
            ai = a + MEM_AW'(i);
            chk("fetch_addr", 32'(fetch_q[i]), 32'({die_m, ai}));
        end
        chk("read_no_err", 32'(err_pulses), 32'(err0));
    endtask

    task automatic do_die(input logic [7:0] v);
        int err0;
        err0 = err_pulses;
        cs_low();
        send_byte(8'hC2);
        send_byte(v);
        spi_bit(1'b1);
        chk("die_oe", 32'(bus.io_oe), 32'h0);
        cs_high_check(4'b0000);
        die_m = v[0];
        chk("active_die", 32'(bus.active_die), 32'(die_m));
        chk("die_no_err", 32'(err_pulses), 32'(err0));
    endtask

    task automatic do_bad(input logic [7:0] op);
        int err0;
        err0 = err_pulses;
        cs_low();
        send_byte(op);
        for (int i = 0; i < 8; i++) spi_bit(1'($urandom));
        chk("bad_oe", 32'(bus.io_oe), 32'h0);
        cs_high_check(4'b0000);
        chk("cmd_err_once", 32'(err_pulses), 32'(err0 + 1));
        chk("bad_die", 32'(bus.active_die), 32'(die_m));
    endtask

    initial begin
        logic [7:0] op;
        int r;
        for (int i = 0; i < (1 << (MEM_AW + 1)); i++) mem[i] = 8'($urandom);
        bus.spi_clk = 1'b0;
        bus.cs_n    = 1'b1;
        bus.io_in   = 4'h0;
        rst = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(1);
        chk("rst_io_out", 32'(bus.io_out), 32'h0);
        chk("rst_io_oe", 32'(bus.io_oe), 32'h0);
        chk("rst_mem_rd", 32'(bus.mem_rd), 32'h0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        chk("rst_die", 32'(bus.active_die), 32'h0);
        chk("rst_cmd_err", 32'(bus.cmd_err), 32'h0);
        wait_clk(4);

        mem[17'h000BB] = 8'hAA;
        do_read(8'h13, 32'h000000BB, 16);
        mem[17'h000AA] = 8'hAA;
        do_read(8'h3C, 32'h000000AA, 4);
        mem[17'h0FFFF] = 8'hAA;
        mem[17'h00000] = 8'h5C;
        do_read(8'h6C, 32'h0000FFFF, 4);

        do_die(8'h01);
        do_read(8'h13, 32'h000000BB, 8);

        do_read(8'h13, 32'h000000BB, 2);
        cs_low();
        for (int i = 0; i < 4; i++) spi_bit(1'b1);
        cs_high_check(4'b0000);
        do_read(8'h6C, 32'h12340100, 6);
        do_bad(8'h9F);
        do_die(8'h00);

        for (int t = 0; t < 16; t++) begin
            r = $urandom_range(0, 4);
            case (r)
                0: do_read(8'h13, $urandom, $urandom_range(0, 20));
                1: do_read(8'h3C, $urandom, $urandom_range(0, 20));
                2: do_read(8'h6C, $urandom, $urandom_range(0, 20));
                3: do_die(8'($urandom));
                default: begin
                    op = 8'($urandom);
                    if (op == 8'h13 || op == 8'h3C || op == 8'h6C || op == 8'hC2) op = 8'h9F;
                    do_bad(op);
                end
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
